// File: rtl/serial_cfg_lut_banked_if.sv
// Bus bundle for serial_cfg_lut_banked: serial config inputs, lookup inputs
// and the registered lookup/status outputs.
interface serial_cfg_lut_banked_if #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 3,
  parameter int unsigned N_BANKS   = 2
);
  localparam int unsigned BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  logic                 d;
  logic                 cs_n;
  logic [BANK_W-1:0]    bank_wr;
  logic [BANK_W-1:0]    bank_rd;
  logic [IN_WIDTH-1:0]  sel;
  logic [OUT_WIDTH-1:0] out;
  logic                 frame_done;
  logic                 load_err;
  logic                 dout;

  modport master (
    output d, cs_n, bank_wr, bank_rd, sel,
    input  out, frame_done, load_err, dout
  );

  modport slave (
    input  d, cs_n, bank_wr, bank_rd, sel,
    output out, frame_done, load_err, dout
  );
endinterface

// File: rtl/serial_cfg_lut_banked.sv
// Serially configured multi-bank LUT. A TABLE_BITS frame is shifted into a
// shadow register and committed atomically into the bank latched on the
// frame's first bit; lookups read any committed bank through a register.
// Optional feature macro: LUT_READBACK_EN (serial readback on dout).
module serial_cfg_lut_banked #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 3,
  parameter int unsigned N_BANKS   = 2
) (
  input logic                    clk,
  input logic                    rst,
  serial_cfg_lut_banked_if.slave bus
);
  localparam int unsigned BANK_W     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned TABLE_BITS = (1 << IN_WIDTH) * OUT_WIDTH;
  localparam int unsigned CNT_W      = (TABLE_BITS > 1) ? $clog2(TABLE_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TABLE_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TABLE_BITS-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
  logic [TABLE_BITS-1:0] bank_q [N_BANKS];
  logic [TABLE_BITS-1:0] bank_d [N_BANKS];
  logic [OUT_WIDTH-1:0]  out_q, out_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_err_q, load_err_d;

  logic [TABLE_BITS-1:0] shifted_c;
  logic                  shift_en_c;
  logic                  commit_c;
  logic [BANK_W-1:0]     commit_bank_c;
  logic [CNT_W-1:0]      rd_idx_c;

  // Shadow contents after shifting in the current serial bit.
  assign shifted_c = TABLE_BITS'({shadow_q, bus.d});
  assign rd_idx_c  = CNT_W'(32'(bus.sel) * OUT_WIDTH);

  // Frame sequencing, commit and lookup next-state logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shadow_d      = shadow_q;
    wr_bank_d     = wr_bank_q;
    bank_d        = bank_q;
    frame_done_d  = 1'b0;
    load_err_d    = load_err_q;
    out_d         = '0;
    shift_en_c    = 1'b0;
    commit_c      = 1'b0;
    commit_bank_c = wr_bank_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!bus.cs_n) begin
          shift_en_c = 1'b1;
          wr_bank_d  = bus.bank_wr;
          bit_cnt_d  = CNT_W'(1);
          state_d    = ST_SHIFT;
          if (TABLE_BITS == 1) begin
            commit_c      = 1'b1;
            commit_bank_c = bus.bank_wr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!bus.cs_n) begin
          shift_en_c = 1'b1;
          if (bit_cnt_q == LAST_CNT) begin
            commit_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          // Aborted frame: shadow is left as-is and never committed.
          bit_cnt_d  = '0;
          load_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (shift_en_c) begin
      shadow_d = shifted_c;
    end

    if (commit_c) begin
      bit_cnt_d    = '0;
      state_d      = ST_DONE;
      frame_done_d = 1'b1;
      if (32'(commit_bank_c) < N_BANKS) begin
        bank_d[commit_bank_c] = shifted_c;
      end else begin
        load_err_d = 1'b1;
      end
    end

    // Lookup reads pre-commit bank contents, so a same-edge commit shows next cycle.
    if (32'(bus.bank_rd) < N_BANKS) begin
      out_d = bank_q[bus.bank_rd][rd_idx_c +: OUT_WIDTH];
    end
  end

  // State, table and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      wr_bank_q    <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        bank_q[b] <= '0;
      end
      out_q        <= '0;
      frame_done_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      wr_bank_q    <= wr_bank_d;
      bank_q       <= bank_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_err   = load_err_q;

`ifdef LUT_READBACK_EN
  logic dout_q, dout_d;

  // Readback presents the shadow MSB that is shifted out on each shifting edge.
  always_comb begin
    dout_d = dout_q;
    if (shift_en_c) begin
      dout_d = shadow_q[TABLE_BITS-1];
    end
  end

  // Readback register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = 1'b0;
`endif
endmodule
